bram_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one port of the true dual-port BRAM between N_REQ core requesters.

---
 rtl/bram_port_arbiter.sv | 93 +++++++++
 tb/tb_bram_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among N_REQ single-word requesters.
// Read data returns to the issuing requester a fixed two cycles after its handshake.
module bram_port_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned AWIDTH = 12,
    parameter int unsigned DWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*AWIDTH-1:0]  req_addr,
    input  logic [N_REQ*DWIDTH-1:0]  req_wdata,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DWIDTH-1:0]        rsp_rdata,
    output logic                     mem_ce,
    output logic                     mem_we,
    output logic [AWIDTH-1:0]        mem_addr,
    output logic [DWIDTH-1:0]        mem_d,
    input  logic [DWIDTH-1:0]        mem_q
);

    localparam int unsigned   IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    logic [IW-1:0]     last_grant_q, last_grant_d;
    logic [IW-1:0]     win_idx, scan_idx;
    logic              hs;

    logic              mem_ce_q, mem_we_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic [DWIDTH-1:0] mem_d_q;

    logic              s1_vld_q;
    logic [IW-1:0]     s1_id_q;
    logic [N_REQ-1:0]  rsp_valid_q;
    logic [DWIDTH-1:0] rdata_hold_q;

    // Rotating-priority scan starting just after the previous winner
    always_comb begin
        hs       = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            scan_idx = IW'((32'(last_grant_q) + k) % N_REQ);
            if (!hs && req_valid[scan_idx]) begin
                hs      = 1'b1;
                win_idx = scan_idx;
            end
        end
        req_ready    = hs ? (N_REQ'(1) << win_idx) : '0;
        last_grant_d = hs ? win_idx : last_grant_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= LAST_IDX;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_d_q      <= '0;
            s1_vld_q     <= 1'b0;
            s1_id_q      <= '0;
            rsp_valid_q  <= '0;
            rdata_hold_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            mem_ce_q     <= hs;
            if (hs) begin
                mem_we_q   <= req_we[win_idx];
                mem_addr_q <= req_addr[win_idx*AWIDTH +: AWIDTH];
                mem_d_q    <= req_wdata[win_idx*DWIDTH +: DWIDTH];
            end
            // Stage 1 tracks the read during its BRAM access; stage 2 is the response slot
            s1_vld_q    <= hs & ~req_we[win_idx];
            s1_id_q     <= win_idx;
            rsp_valid_q <= s1_vld_q ? (N_REQ'(1) << s1_id_q) : '0;
            if (|rsp_valid_q) begin
                rdata_hold_q <= mem_q;
            end
        end
    end

    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_d     = mem_d_q;
    assign rsp_valid = rsp_valid_q;
    // BRAM output is live during the response cycle; hold it afterwards
    assign rsp_rdata = (|rsp_valid_q) ? mem_q : rdata_hold_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model (round-robin rule, shadow memory, response queue).
module tb_bram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 16;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_ce, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_d, mem_q;

    logic [DW-1:0]   bram [0:4095];
    logic            pk_en = 1'b0;
    logic [AW-1:0]   pk_addr;
    logic [DW-1:0]   pk_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    bram_port_arbiter #(.N_REQ(N), .AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Single-port BRAM model with 1-cycle read latency plus a bench preload path
    always @(posedge clk) begin
        if (pk_en) bram[pk_addr] <= pk_data;
        else if (mem_ce) begin
            if (mem_we) bram[mem_addr] <= mem_d;
            else        mem_q <= bram[mem_addr];
        end
    end

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pk_en = 1'b1; pk_addr = a; pk_data = d;
        @(posedge clk); #1 pk_en = 1'b0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = '0;
        #1;
        checks++;
        if ({mem_ce, mem_we, mem_addr, mem_d, rsp_valid, rsp_rdata, req_ready} !== '0) begin
            failures++; $display("FAIL reset_outputs got ce=%b we=%b addr=%h d=%h rv=%b rd=%h rdy=%b exp all 0",
                mem_ce, mem_we, mem_addr, mem_d, rsp_valid, rsp_rdata, req_ready);
        end
        do_reset;
        repeat (2) begin
            @(negedge clk); checks++;
            if ({mem_ce, mem_addr, mem_d, rsp_valid, rsp_rdata, req_ready} !== '0) begin
                failures++; $display("FAIL post_reset_idle got ce=%b addr=%h d=%h rv=%b rd=%h exp 0",
                    mem_ce, mem_addr, mem_d, rsp_valid, rsp_rdata);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_read_basic;
        do_reset;
        poke(12'h005, 16'hBEEF);
        set_req(0, 1'b0, 12'h005, '0);
        @(negedge clk); checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL rd_ready got=%b exp=0001", req_ready); end
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(negedge clk); checks++;
        if ({mem_ce, mem_we, mem_addr} !== {1'b1, 1'b0, 12'h005}) begin
            failures++; $display("FAIL rd_cmd got ce=%b we=%b addr=%h exp 1 0 005", mem_ce, mem_we, mem_addr);
        end
        checks++;
        if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rd_early_rsp got=%b exp=0000", rsp_valid); end
        @(posedge clk); #1;
        @(negedge clk); checks++;
        if ({rsp_valid, rsp_rdata} !== {4'b0001, 16'hBEEF}) begin
            failures++; $display("FAIL rd_rsp got rv=%b rd=%h exp 0001 beef", rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk); checks++;
        if ({rsp_valid, rsp_rdata, mem_ce, mem_addr} !== {4'b0000, 16'hBEEF, 1'b0, 12'h005}) begin
            failures++; $display("FAIL rd_hold got rv=%b rd=%h ce=%b addr=%h exp 0000 beef 0 005",
                rsp_valid, rsp_rdata, mem_ce, mem_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_all_valid;
        do_reset;
        for (int i = 0; i < N; i++) poke(12'(32'h20 + i), 16'(32'hA000 + i));
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 12'(32'h20 + i), '0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); checks++;
            if (req_ready !== (4'b0001 << (c % N))) begin
                failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, 4'b0001 << (c % N));
            end
            if (c >= 2) begin
                checks++;
                if ({rsp_valid, rsp_rdata} !== {4'b0001 << ((c - 2) % N), 16'(32'hA000 + (c - 2) % N)}) begin
                    failures++; $display("FAIL rr_rsp c=%0d got rv=%b rd=%h exp rv=%b rd=%h", c, rsp_valid,
                        rsp_rdata, 4'b0001 << ((c - 2) % N), 16'(32'hA000 + (c - 2) % N));
                end
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        do_reset;
        poke(12'h010, 16'h0000);
        set_req(1, 1'b1, 12'h010, 16'h1234);
        @(negedge clk); checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL wr_ready got=%b exp=0010", req_ready); end
        @(posedge clk); #1 req_valid[1] = 1'b0;
        set_req(2, 1'b0, 12'h010, '0);
        @(negedge clk); checks++;
        if ({mem_ce, mem_we, mem_addr, mem_d} !== {1'b1, 1'b1, 12'h010, 16'h1234}) begin
            failures++; $display("FAIL wr_cmd got ce=%b we=%b addr=%h d=%h exp 1 1 010 1234", mem_ce, mem_we, mem_addr, mem_d);
        end
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL raw_ready got=%b exp=0100", req_ready); end
        @(posedge clk); #1 req_valid[2] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); checks++;
        if ({rsp_valid, rsp_rdata} !== {4'b0100, 16'h1234}) begin
            failures++; $display("FAIL raw_rsp got rv=%b rd=%h exp 0100 1234", rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_priority;
        do_reset;
        set_req(1, 1'b0, 12'h001, '0);
        @(negedge clk); checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL prio_setup got=%b exp=0010", req_ready); end
        @(posedge clk); #1 req_valid[1] = 1'b0;
        set_req(1, 1'b0, 12'h002, '0);
        set_req(3, 1'b0, 12'h003, '0);
        @(negedge clk); checks++;
        if (req_ready !== 4'b1000) begin failures++; $display("FAIL prio_first got=%b exp=1000", req_ready); end
        @(posedge clk); #1 req_valid[3] = 1'b0;
        @(negedge clk); checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL prio_second got=%b exp=0010", req_ready); end
        @(posedge clk); #1 req_valid[1] = 1'b0;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_reset_midop;
        do_reset;
        set_req(0, 1'b0, 12'h005, '0);
        @(negedge clk); checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ready got=%b exp=0001", req_ready); end
        @(posedge clk); #1 req_valid[0] = 1'b0;
        checks++;
        if (mem_ce !== 1'b1) begin failures++; $display("FAIL mid_ce_before got=%b exp=1", mem_ce); end
        #1 reset = 1'b1;
        #1; checks++;
        if ({mem_ce, rsp_valid, mem_addr} !== '0) begin
            failures++; $display("FAIL mid_reset_now got ce=%b rv=%b addr=%h exp 0", mem_ce, rsp_valid, mem_addr);
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); checks++;
            if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL mid_no_rsp c=%0d got=%b exp=0000", c, rsp_valid); end
            @(posedge clk); #1;
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 12'(i), '0);
        for (int c = 0; c < N; c++) begin
            @(negedge clk); checks++;
            if (req_ready !== (4'b0001 << c)) begin
                failures++; $display("FAIL mid_regrant c=%0d got=%b exp=%b", c, req_ready, 4'b0001 << c);
            end
            @(posedge clk); #1 req_valid[c] = 1'b0;
        end
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_idle;
        do_reset;
        set_req(2, 1'b1, 12'h030, 16'h5555);
        @(negedge clk); checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL idle_setup got=%b exp=0100", req_ready); end
        @(posedge clk); #1 req_valid[2] = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); checks++;
            if ({req_ready, mem_ce, rsp_valid} !== '0) begin
                failures++; $display("FAIL idle c=%0d got rdy=%b ce=%b rv=%b exp 0", c, req_ready, mem_ce, rsp_valid);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 12'h030, '0);
        for (int k = 0; k < N; k++) begin
            @(negedge clk); checks++;
            if (req_ready !== (4'b0001 << ((3 + k) % N))) begin
                failures++; $display("FAIL idle_prio k=%0d got=%b exp=%b", k, req_ready, 4'b0001 << ((3 + k) % N));
            end
            @(posedge clk); #1 req_valid[(3 + k) % N] = 1'b0;
        end
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [DW-1:0] shadow [0:15];
        rsp_t          rq [$];
        int            lg, g, cyc;
        logic          exp_ce, exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_d;
        for (int a = 0; a < 16; a++) begin
            shadow[a] = 16'($urandom);
            poke(12'(a), shadow[a]);
        end
        do_reset;
        lg = N - 1; cyc = 0;
        exp_ce = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_d = '0;
        for (int i = 0; i < N; i++)
            if ($urandom_range(0, 2) != 0) set_req(i, 1'(($urandom_range(0, 1))), 12'($urandom_range(0, 15)), 16'($urandom));
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            g = -1;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (lg + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
            checks++;
            if (req_ready !== ((g >= 0) ? (4'b0001 << g) : 4'b0000)) begin
                failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp_winner=%0d", cyc, req_ready, g);
            end
            checks++;
            if ({mem_ce, mem_addr, mem_d} !== {exp_ce, exp_addr, exp_d}) begin
                failures++; $display("FAIL rnd_cmd cyc=%0d got ce=%b addr=%h d=%h exp ce=%b addr=%h d=%h",
                    cyc, mem_ce, mem_addr, mem_d, exp_ce, exp_addr, exp_d);
            end
            if (exp_ce) begin
                checks++;
                if (mem_we !== exp_we) begin failures++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, mem_we, exp_we); end
            end
            checks++;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                if ({rsp_valid, rsp_rdata} !== {4'b0001 << rq[0].id, rq[0].data}) begin
                    failures++; $display("FAIL rnd_rsp cyc=%0d got rv=%b rd=%h exp rv=%b rd=%h",
                        cyc, rsp_valid, rsp_rdata, 4'b0001 << rq[0].id, rq[0].data);
                end
                void'(rq.pop_front());
            end else if (rsp_valid !== 4'b0000) begin
                failures++; $display("FAIL rnd_no_rsp cyc=%0d got=%b exp=0000", cyc, rsp_valid);
            end
            exp_ce = (g >= 0);
            if (g >= 0) begin
                exp_we   = req_we[g];
                exp_addr = req_addr[g*AW +: AW];
                exp_d    = req_wdata[g*DW +: DW];
                if (exp_we) shadow[exp_addr[3:0]] = exp_d;
                else        rq.push_back('{due: cyc + 2, id: g, data: shadow[exp_addr[3:0]]});
                lg = g;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (g >= 0) req_valid[g] = 1'b0;
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 1'(($urandom_range(0, 1))), 12'($urandom_range(0, 15)), 16'($urandom));
        end
        req_valid = '0;
        repeat (3) @(posedge clk); #1;
    endtask

    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        @(posedge clk); #1;
        test_reset;
        test_read_basic;
        test_all_valid;
        test_write_read;
        test_priority;
        test_reset_midop;
        test_idle;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
